// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: one WIDTH-bit carry look-ahead slice reused over WORDS words, LSW first.
// Optional subtract support is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   input  logic                   cIn,
`ifdef CLA_SEQ_SUB_EN
   input  logic                   sub,
`endif
   output logic                   outValid,
   input  logic                   outReady,
   output logic [WIDTH*WORDS-1:0] sum,
   output logic                   cOut,
   output logic                   ovf,
   output logic                   busy
);

   localparam int N    = WIDTH * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      a_q, b_q, sum_q, sum_d;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q, cout_q, ovf_q;
   logic              accept_s, last_s;
   logic [N-1:0]      b_eff_s;
   logic              cin_eff_s;
   logic [WIDTH-1:0]  x_s, y_s, g_s, p_s, s_s;
   logic [WIDTH:0]    cc_s;

   assign accept_s = inValid && (state_q == S_IDLE);
   assign last_s   = (idx_q == IDXW'(WORDS - 1));

   // Operand conditioning at accept; subtraction is folded into B and the initial carry.
   always_comb begin
`ifdef CLA_SEQ_SUB_EN
      if (sub) begin
         b_eff_s   = ~b;
         cin_eff_s = 1'b1;
      end else begin
         b_eff_s   = b;
         cin_eff_s = cIn;
      end
`else
      b_eff_s   = b;
      cin_eff_s = cIn;
`endif
   end

   // Word select: pick the current operand words out of the latched operands.
   always_comb begin
      x_s = '0;
      y_s = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IDXW'(w)) begin
            x_s = a_q[w*WIDTH +: WIDTH];
            y_s = b_q[w*WIDTH +: WIDTH];
         end else begin
            x_s = x_s;
            y_s = y_s;
         end
      end
   end

   // Carry look-ahead slice; cc_s[i] is the carry into bit i, cc_s[WIDTH] the slice carry-out.
   always_comb begin
      g_s     = x_s & y_s;
      p_s     = x_s ^ y_s;
      cc_s    = '0;
      cc_s[0] = carry_q;
      for (int i = 0; i < WIDTH; i++) begin
         cc_s[i+1] = g_s[i] | (p_s[i] & cc_s[i]);
      end
      s_s = p_s ^ cc_s[WIDTH-1:0];
   end

   // Result word merge: only the word selected by idx is replaced.
   always_comb begin
      sum_d = sum_q;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IDXW'(w)) begin
            sum_d[w*WIDTH +: WIDTH] = s_s;
         end else begin
            sum_d[w*WIDTH +: WIDTH] = sum_q[w*WIDTH +: WIDTH];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (inValid) state_d = S_RUN;
            else         state_d = S_IDLE;
         end
         S_RUN: begin
            if (last_s) state_d = S_DONE;
            else        state_d = S_RUN;
         end
         S_DONE: begin
            if (outReady) state_d = S_IDLE;
            else          state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output decode; these flags come straight from the state register.
   always_comb begin
      inReady  = 1'b0;
      outValid = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_IDLE: inReady = 1'b1;
         S_RUN:  busy    = 1'b1;
         S_DONE: begin
            outValid = 1'b1;
            busy     = 1'b1;
         end
         default: inReady = 1'b0;
      endcase
   end

   // Datapath registers: operand capture, per-word sum/carry update, final flags.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept_s) begin
         a_q     <= a;
         b_q     <= b_eff_s;
         carry_q <= cin_eff_s;
         idx_q   <= '0;
      end else if (state_q == S_RUN) begin
         sum_q   <= sum_d;
         carry_q <= cc_s[WIDTH];
         if (last_s) begin
            idx_q  <= '0;
            cout_q <= cc_s[WIDTH];
            ovf_q  <= cc_s[WIDTH] ^ cc_s[WIDTH-1];
         end else begin
            idx_q  <= idx_q + IDXW'(1);
         end
      end
   end

   assign sum  = sum_q;
   assign cOut = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed, table-driven bench for cla_seq_adder (WIDTH=8, WORDS=4), plus backpressure,
// mid-operation reset and (when CLA_SEQ_SUB_EN is defined) subtraction sequences.
module tb_cla_seq_adder;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int N     = WIDTH * WORDS;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          inValid = 1'b0;
   logic          inReady;
   logic [N-1:0]  a_s = '0;
   logic [N-1:0]  b_s = '0;
   logic          cin_s = 1'b0;
`ifdef CLA_SEQ_SUB_EN
   logic          sub_s = 1'b0;
`else
   logic          sub_unused = 1'b0;
`endif
   logic          outValid;
   logic          outReady = 1'b0;
   logic [N-1:0]  sum;
   logic          cOut;
   logic          ovf;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] va;
      logic [N-1:0] vb;
      logic         vcin;
      logic [N-1:0] esum;
      logic         ecout;
      logic         eovf;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk      (clk),
      .rstN     (rstN),
      .inValid  (inValid),
      .inReady  (inReady),
      .a        (a_s),
      .b        (b_s),
      .cIn      (cin_s),
`ifdef CLA_SEQ_SUB_EN
      .sub      (sub_s),
`endif
      .outValid (outValid),
      .outReady (outReady),
      .sum      (sum),
      .cOut     (cOut),
      .ovf      (ovf),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present operands in IDLE and let one edge accept them; returns #1 after the accept edge.
   task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb2, input logic tc, input logic ts);
      a_s     = ta;
      b_s     = tb2;
      cin_s   = tc;
`ifdef CLA_SEQ_SUB_EN
      sub_s   = ts;
`else
      sub_unused = ts;
`endif
      inValid = 1'b1;
      chk("inReady_idle", {63'd0, inReady}, 64'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   // Count edges after accept until outValid; an expired bound counts as a failure.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!outValid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!outValid) begin
         errors++;
         checks++;
         $display("FAIL wait_valid: outValid never rose within %0d cycles", lat);
      end
   endtask

   task automatic release_result();
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      chk("inReady_after_release", {63'd0, inReady}, 64'd1);
      chk("outValid_after_release", {63'd0, outValid}, 64'd0);
   endtask

   task automatic do_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb2,
                        input logic tc, input logic ts, input logic [N-1:0] es,
                        input logic ec, input logic eo);
      int lat;
      issue(ta, tb2, tc, ts);
      chk({name, "_busy"}, {63'd0, busy}, 64'd1);
      chk({name, "_inReady_run"}, {63'd0, inReady}, 64'd0);
      wait_valid(lat);
      chk({name, "_latency"}, 64'(lat), 64'(WORDS));
      chk({name, "_sum"}, 64'(sum), 64'(es));
      chk({name, "_cOut"}, {63'd0, cOut}, {63'd0, ec});
      chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      release_result();
   endtask

   initial begin
      int lat;
      vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
      vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};

      #12;
      chk("rst_inReady", {63'd0, inReady}, 64'd1);
      chk("rst_outValid", {63'd0, outValid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cOut", {63'd0, cOut}, 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, 1'b0,
               vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
      end

      // Backpressure: result held, new operands ignored while DONE stalls.
      issue(32'h00000001, 32'h00000002, 1'b0, 1'b0);
      wait_valid(lat);
      a_s     = 32'h00000010;
      b_s     = 32'h00000020;
      cin_s   = 1'b0;
      inValid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk("bp_sum", 64'(sum), 64'h3);
         chk("bp_outValid", {63'd0, outValid}, 64'd1);
         chk("bp_inReady", {63'd0, inReady}, 64'd0);
         chk("bp_cOut", {63'd0, cOut}, 64'd0);
      end
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      chk("bp_idle_inReady", {63'd0, inReady}, 64'd1);
      chk("bp_idle_busy", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      chk("bp_second_accept_busy", {63'd0, busy}, 64'd1);
      wait_valid(lat);
      chk("bp_second_latency", 64'(lat), 64'(WORDS));
      chk("bp_second_sum", 64'(sum), 64'h30);
      release_result();

      // Reset mid-operation after two RUN cycles.
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      chk("mid_rst_outValid", {63'd0, outValid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_inReady", {63'd0, inReady}, 64'd1);
      chk("mid_rst_sum", 64'(sum), 64'd0);
      chk("mid_rst_cOut", {63'd0, cOut}, 64'd0);
      chk("mid_rst_ovf", {63'd0, ovf}, 64'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("post_rst_no_outValid", {63'd0, outValid}, 64'd0);
      end
      do_op("post_rst_3p4", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
      do_op("sub_5m7", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      do_op("sub_7m5", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
      do_op("sub_cin_ignored", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder controller that time-shares a single WIDTH-bit carry look-ahead slice across WORDS operand words. It adds two WIDTH*WORDS-bit operands least-significant word first, one word per cycle, chaining each slice's carry-out into the next word's carry-in. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is used where a full-width carry look-ahead adder is too large and multi-cycle latency is acceptable.

## Interface
- WIDTH, 8: bits per slice; the internal g/p/carry look-ahead network is this wide.
- WORDS, 4: number of slices per operation; must be ≥1; total operand width is N = WIDTH*WORDS.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- inValid  in  1  operands valid.
- inReady  out  1  block can accept operands.
- a  in  N  operand A.
- b  in  N  operand B.
- cIn  in  1  carry into word 0.
- sub  in  1  subtract request; port exists only when CLA_SEQ_SUB_EN is defined.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts result.
- sum  out  N  registered result.
- cOut  out  1  carry out of the top word.
- ovf  out  1  two's-complement overflow of the N-bit result.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - inReady=1.
  - On inValid&&inReady: latch a, b and cIn into operand registers; carry register ← cIn; word index idx ← 0; go to RUN.
- RUN:
  - Slice inputs: x = A[idx], y = B[idx].
  - Generate and propagate: g = x&y, p = x^y.
  - Carry chain: c[0] = g[0] | p[0]&carry; c[i] = g[i] | p[i]&c[i-1].
  - Slice sum: s[0] = p[0]^carry; s[i] = p[i]^c[i-1].
  - At the clock edge: sum word idx ← s; carry ← c[WIDTH-1]; idx ← idx+1.
  - On the word with idx == WORDS-1: cOut ← c[WIDTH-1]; ovf ← c[WIDTH-1]^c[WIDTH-2] (for WIDTH=1, ovf ← c[0]^carry); go to DONE.
- DONE:
  - outValid=1.
  - sum, cOut and ovf are held stable.
  - On outReady: go to IDLE.
- inReady is asserted only in IDLE. inValid outside IDLE is ignored, and the operands are not captured.
- Arithmetic is unsigned modulo 2^N; cOut is bit N of a+b+cIn.
- idx counter width is max(1, $clog2(WORDS)). It never exceeds WORDS-1.
- Sum words not yet computed in RUN hold their previous values. The sum port is only meaningful while outValid=1.
- Reset values: state IDLE, inReady=1, outValid=0, busy=0, sum=0, cOut=0, ovf=0, idx=0, carry=0.
- Reset asserted mid-operation aborts the operation immediately. No outValid is produced and the block returns to IDLE.

## Timing
- Accept at edge E0.
- RUN occupies edges E1..E(WORDS). outValid rises after edge E(WORDS), so latency is WORDS cycles from accept to outValid.
- Result handshake at edge Ek: IDLE and inReady=1 in the following cycle. The next accept is possible at Ek+1.
- Peak throughput: one operation per WORDS+2 cycles.
- WORDS=1: a single RUN cycle, then DONE.
- outReady held high during RUN has no effect. outReady held low in DONE stalls the block indefinitely with outputs stable.
- Only registered outputs, except inReady, outValid and busy, which decode the state register directly.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - The sub port exists and is latched at accept.
  - When sub=1, B is replaced by ~B and carry ← 1 (cIn is ignored), producing a−b.
  - cOut=1 means no borrow.
- CLA_SEQ_SUB_EN undefined:
  - No sub port; the block is add only.
  - The inversion logic is absent.

## Test plan
- WIDTH=8, WORDS=4, a=0x000000FF, b=0x00000001, cIn=0 → outValid 4 cycles after accept; sum=0x00000100, cOut=0, ovf=0.
- a=0xFFFFFFFF, b=0x00000000, cIn=1 → sum=0x00000000, cOut=1, ovf=0 (carry ripples through all 4 words).
- a=0x7FFFFFFF, b=0x00000001, cIn=0 → sum=0x80000000, cOut=0, ovf=1.
- Backpressure: outReady=0 for 6 cycles in DONE, with inValid=1 and new operands presented:
  - sum, cOut and ovf remain stable; inReady=0; the new operands are not captured.
  - After outReady=1, the second operation is accepted one cycle later.
- Reset mid-operation: rstN low after 2 RUN cycles → all outputs return to reset values immediately; no outValid; a fresh add of 3+4 afterwards gives sum=0x00000007.
- With CLA_SEQ_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFFFFFE, cOut=0; a=7, b=5, sub=1 → sum=0x00000002, cOut=1.
